// File: rtl/dvi_tmds_encoder.sv
// DVI TMDS encoder: 4-bit RGB expanded to 8 bits and encoded into three 10-bit
// TMDS symbol streams with control tokens during blanking; two-clock latency.
module dvi_tmds_encoder #(
  parameter logic INVERT_SYNC = 1'b0
) (
  input  logic       clk,
  input  logic       reset_i,
  input  logic [3:0] red_i,
  input  logic [3:0] green_i,
  input  logic [3:0] blue_i,
  input  logic       hsync_i,
  input  logic       vsync_i,
  input  logic       dv_de_i,
  output logic [9:0] tmds_red_o,
  output logic [9:0] tmds_green_o,
  output logic [9:0] tmds_blue_o,
  output logic       hsync_o,
  output logic       vsync_o,
  output logic       dv_de_o
);

  // Streaming pipeline: no valid/ready handshake, one pixel accepted per clock.
  localparam logic [9:0] TOKEN_00 = 10'b1101010100;
  localparam logic [9:0] TOKEN_01 = 10'b0010101011;
  localparam logic [9:0] TOKEN_10 = 10'b0101010100;
  localparam logic [9:0] TOKEN_11 = 10'b1010101011;

  function automatic logic [3:0] ones8(input logic [7:0] d);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < 8; i++) n = n + 4'(d[i]);
    return n;
  endfunction

  function automatic logic [8:0] tm_min(input logic [7:0] d);
    logic [3:0] n;
    logic       use_xnor;
    logic [8:0] q;
    n        = ones8(d);
    use_xnor = (n > 4'd4) || ((n == 4'd4) && !d[0]);
    q        = 9'd0;
    q[0]     = d[0];
    for (int i = 1; i < 8; i++)
      q[i] = use_xnor ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
    q[8] = ~use_xnor;
    return q;
  endfunction

  // Returns {next_cnt, symbol}; diff is N1-N0 of q_m[7:0].
  function automatic logic [14:0] tmds_enc(input logic [8:0] qm, input logic [3:0] n1,
                                           input logic signed [4:0] cnt);
    logic signed [4:0] diff;
    logic signed [4:0] cnt_n;
    logic [9:0]        sym;
    diff = $signed({n1, 1'b0}) - 5'sd8;
    if (cnt == 5'sd0 || n1 == 4'd4) begin
      sym   = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
      cnt_n = cnt + (qm[8] ? diff : -diff);
    end else if ((cnt > 5'sd0 && n1 > 4'd4) || (cnt < 5'sd0 && n1 < 4'd4)) begin
      sym   = {1'b1, qm[8], ~qm[7:0]};
      cnt_n = cnt + (qm[8] ? 5'sd2 : 5'sd0) - diff;
    end else begin
      sym   = {1'b0, qm[8], qm[7:0]};
      cnt_n = cnt + diff - (qm[8] ? 5'sd0 : 5'sd2);
    end
    return {cnt_n, sym};
  endfunction

  function automatic logic [9:0] ctrl_token(input logic [1:0] c);
    logic [9:0] t;
    case (c)
      2'b00:   t = TOKEN_00;
      2'b01:   t = TOKEN_01;
      2'b10:   t = TOKEN_10;
      default: t = TOKEN_11;
    endcase
    return t;
  endfunction

  logic [8:0]        qm_r_d, qm_g_d, qm_b_d;
  logic [8:0]        qm_r, qm_g, qm_b;
  logic [3:0]        n1_r, n1_g, n1_b;
  logic              de1, hs1, vs1;
  logic signed [4:0] cnt_r, cnt_g, cnt_b;
  logic [14:0]       enc_r, enc_g, enc_b;

  always_comb begin
    qm_r_d = tm_min({red_i, red_i});
    qm_g_d = tm_min({green_i, green_i});
    qm_b_d = tm_min({blue_i, blue_i});
  end

  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      de1  <= 1'b0;
      hs1  <= 1'b0;
      vs1  <= 1'b0;
      qm_r <= 9'd0;
      qm_g <= 9'd0;
      qm_b <= 9'd0;
      n1_r <= 4'd0;
      n1_g <= 4'd0;
      n1_b <= 4'd0;
    end else begin
      de1  <= dv_de_i;
      hs1  <= hsync_i ^ INVERT_SYNC;
      vs1  <= vsync_i ^ INVERT_SYNC;
      qm_r <= qm_r_d;
      qm_g <= qm_g_d;
      qm_b <= qm_b_d;
      n1_r <= ones8(qm_r_d[7:0]);
      n1_g <= ones8(qm_g_d[7:0]);
      n1_b <= ones8(qm_b_d[7:0]);
    end
  end

  always_comb begin
    enc_r = tmds_enc(qm_r, n1_r, cnt_r);
    enc_g = tmds_enc(qm_g, n1_g, cnt_g);
    enc_b = tmds_enc(qm_b, n1_b, cnt_b);
  end

  // Blanking forces disparity to zero so the first active pixel starts balanced.
  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      tmds_red_o   <= TOKEN_00;
      tmds_green_o <= TOKEN_00;
      tmds_blue_o  <= TOKEN_00;
      hsync_o      <= 1'b0;
      vsync_o      <= 1'b0;
      dv_de_o      <= 1'b0;
      cnt_r        <= 5'sd0;
      cnt_g        <= 5'sd0;
      cnt_b        <= 5'sd0;
    end else begin
      hsync_o <= hs1;
      vsync_o <= vs1;
      dv_de_o <= de1;
      if (de1) begin
        tmds_red_o   <= enc_r[9:0];
        tmds_green_o <= enc_g[9:0];
        tmds_blue_o  <= enc_b[9:0];
        cnt_r        <= enc_r[14:10];
        cnt_g        <= enc_g[14:10];
        cnt_b        <= enc_b[14:10];
      end else begin
        tmds_red_o   <= TOKEN_00;
        tmds_green_o <= TOKEN_00;
        tmds_blue_o  <= ctrl_token({vs1, hs1});
        cnt_r        <= 5'sd0;
        cnt_g        <= 5'sd0;
        cnt_b        <= 5'sd0;
      end
    end
  end

endmodule

// File: tb/tb_dvi_tmds_encoder.sv
// Bench for dvi_tmds_encoder: integer reference model of the TMDS rules feeding
// an expected queue, plus directed golden-symbol checks.
module tb_dvi_tmds_encoder;

  localparam logic [9:0] TOK00 = 10'b1101010100;

  logic       clk = 1'b0;
  logic       reset_i;
  logic [3:0] red_i, green_i, blue_i;
  logic       hsync_i, vsync_i, dv_de_i;
  logic [9:0] tmds_red_o, tmds_green_o, tmds_blue_o;
  logic       hsync_o, vsync_o, dv_de_o;
  logic [9:0] inv_red, inv_green, inv_blue;
  logic       inv_hs, inv_vs, inv_de;

  int          n_vec = 0;
  int          n_err = 0;
  int          mcnt[3];
  logic [32:0] exp_q[$];
  logic [32:0] exp_w;

  always #5 clk = ~clk;

  dvi_tmds_encoder #(.INVERT_SYNC(1'b0)) dut (
    .clk(clk), .reset_i(reset_i), .red_i(red_i), .green_i(green_i), .blue_i(blue_i),
    .hsync_i(hsync_i), .vsync_i(vsync_i), .dv_de_i(dv_de_i),
    .tmds_red_o(tmds_red_o), .tmds_green_o(tmds_green_o), .tmds_blue_o(tmds_blue_o),
    .hsync_o(hsync_o), .vsync_o(vsync_o), .dv_de_o(dv_de_o)
  );

  dvi_tmds_encoder #(.INVERT_SYNC(1'b1)) dut_inv (
    .clk(clk), .reset_i(reset_i), .red_i(red_i), .green_i(green_i), .blue_i(blue_i),
    .hsync_i(hsync_i), .vsync_i(vsync_i), .dv_de_i(dv_de_i),
    .tmds_red_o(inv_red), .tmds_green_o(inv_green), .tmds_blue_o(inv_blue),
    .hsync_o(inv_hs), .vsync_o(inv_vs), .dv_de_o(inv_de)
  );

  function automatic logic [9:0] tok(input logic [1:0] c);
    case (c)
      2'b00:   return 10'b1101010100;
      2'b01:   return 10'b0010101011;
      2'b10:   return 10'b0101010100;
      default: return 10'b1010101011;
    endcase
  endfunction

  function automatic logic [32:0] obs_word();
    return {hsync_o, vsync_o, dv_de_o, tmds_red_o, tmds_green_o, tmds_blue_o};
  endfunction

  // Integer model of one channel: transition minimisation then DC balancing.
  task automatic model_ch(input logic [7:0] d, input int ch, output logic [9:0] sym);
    int         n1d, n1, n0, q8;
    logic       xm;
    logic [7:0] q;
    n1d  = $countones(d);
    xm   = (n1d > 4) || (n1d == 4 && d[0] == 1'b0);
    q    = 8'd0;
    q[0] = d[0];
    for (int i = 1; i < 8; i++) q[i] = xm ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
    q8 = xm ? 0 : 1;
    n1 = $countones(q);
    n0 = 8 - n1;
    if (mcnt[ch] == 0 || n1 == n0) begin
      sym = (q8 == 1) ? {2'b01, q} : {2'b10, ~q};
      mcnt[ch] += (q8 == 1) ? (n1 - n0) : (n0 - n1);
    end else if ((mcnt[ch] > 0 && n1 > n0) || (mcnt[ch] < 0 && n0 > n1)) begin
      sym = {1'b1, q8[0], ~q};
      mcnt[ch] += 2 * q8 + (n0 - n1);
    end else begin
      sym = {1'b0, q8[0], q};
      mcnt[ch] += (n1 - n0) - 2 * (1 - q8);
    end
  endtask

  task automatic push_model(input logic de, input logic hs, input logic vs,
                            input logic [3:0] r, input logic [3:0] g, input logic [3:0] b);
    logic [9:0] sr, sg, sb;
    if (de) begin
      model_ch({r, r}, 2, sr);
      model_ch({g, g}, 1, sg);
      model_ch({b, b}, 0, sb);
    end else begin
      sr = TOK00;
      sg = TOK00;
      sb = tok({vs, hs});
      for (int c = 0; c < 3; c++) mcnt[c] = 0;
    end
    exp_q.push_back({hs, vs, de, sr, sg, sb});
  endtask

  task automatic model_reset();
    exp_q.delete();
    exp_q.push_back({3'b000, TOK00, TOK00, TOK00});
    for (int c = 0; c < 3; c++) mcnt[c] = 0;
  endtask

  task automatic step(input logic de, input logic hs, input logic vs,
                      input logic [3:0] r, input logic [3:0] g, input logic [3:0] b);
    dv_de_i = de; hsync_i = hs; vsync_i = vs;
    red_i = r; green_i = g; blue_i = b;
    push_model(de, hs, vs, r, g, b);
    @(posedge clk);
    #1;
    exp_w = exp_q.pop_front();
  endtask

  function automatic logic [3:0] rc();
    return 4'($urandom_range(0, 15));
  endfunction

  task automatic test_reset();
    reset_i = 1'b1;
    dv_de_i = 1'b0; hsync_i = 1'b0; vsync_i = 1'b0;
    red_i = 4'd0; green_i = 4'd0; blue_i = 4'd0;
    #2;
    n_vec++;
    if (obs_word() !== {3'b000, TOK00, TOK00, TOK00}) begin
      n_err++;
      $display("FAIL reset_initial: got %h expected %h", obs_word(), {3'b000, TOK00, TOK00, TOK00});
    end
    @(posedge clk);
    #1;
    n_vec++;
    if (obs_word() !== {3'b000, TOK00, TOK00, TOK00}) begin
      n_err++;
      $display("FAIL reset_held: got %h expected %h", obs_word(), {3'b000, TOK00, TOK00, TOK00});
    end
    reset_i = 1'b0;
    model_reset();
  endtask

  task automatic test_blanking();
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 1'b0, rc(), rc(), rc());
      n_vec++;
      if (obs_word() !== exp_w) begin
        n_err++;
        $display("FAIL blanking_model[%0d]: got %h expected %h", i, obs_word(), exp_w);
      end
    end
    n_vec++;
    if (tmds_blue_o !== 10'b0010101011 || tmds_green_o !== TOK00 || tmds_red_o !== TOK00 ||
        hsync_o !== 1'b1) begin
      n_err++;
      $display("FAIL blanking_golden: got b=%b g=%b r=%b hs=%b expected b=0010101011 g=r=%b hs=1",
               tmds_blue_o, tmds_green_o, tmds_red_o, hsync_o, TOK00);
    end
  endtask

  task automatic test_black();
    logic [9:0] gold[3];
    gold[0] = 10'b0100000000;
    gold[1] = 10'b1111111111;
    gold[2] = 10'b0100000000;
    for (int i = 0; i < 4; i++) begin
      step(i < 3, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0);
      n_vec++;
      if (obs_word() !== exp_w) begin
        n_err++;
        $display("FAIL black_model[%0d]: got %h expected %h", i, obs_word(), exp_w);
      end
      if (i >= 1) begin
        n_vec++;
        if (tmds_red_o !== gold[i-1] || tmds_green_o !== gold[i-1] || tmds_blue_o !== gold[i-1]) begin
          n_err++;
          $display("FAIL black_golden[%0d]: got r=%b g=%b b=%b expected %b",
                   i - 1, tmds_red_o, tmds_green_o, tmds_blue_o, gold[i-1]);
        end
      end
    end
  endtask

  task automatic test_white();
    logic [9:0] gold[2];
    gold[0] = 10'b1000000000;
    gold[1] = 10'b0011111111;
    for (int i = 0; i < 4; i++) begin
      step(i < 2, 1'b0, 1'b0, 4'hF, 4'hF, 4'hF);
      n_vec++;
      if (obs_word() !== exp_w) begin
        n_err++;
        $display("FAIL white_model[%0d]: got %h expected %h", i, obs_word(), exp_w);
      end
      if (i == 1 || i == 2) begin
        n_vec++;
        if (tmds_red_o !== gold[i-1] || tmds_green_o !== gold[i-1] || tmds_blue_o !== gold[i-1]) begin
          n_err++;
          $display("FAIL white_golden[%0d]: got r=%b g=%b b=%b expected %b",
                   i - 1, tmds_red_o, tmds_green_o, tmds_blue_o, gold[i-1]);
        end
      end
    end
  endtask

  task automatic test_dc_balance();
    int acc[3];
    int mx;
    int a;
    mx = 0;
    for (int c = 0; c < 3; c++) acc[c] = 0;
    for (int i = 0; i < 10002; i++) begin
      step(i < 10000, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rc(), rc(), rc());
      n_vec++;
      if (obs_word() !== exp_w) begin
        n_err++;
        $display("FAIL dc_model[%0d]: got %h expected %h", i, obs_word(), exp_w);
      end
      if (dv_de_o === 1'b1) begin
        acc[2] += 2 * $countones(tmds_red_o) - 10;
        acc[1] += 2 * $countones(tmds_green_o) - 10;
        acc[0] += 2 * $countones(tmds_blue_o) - 10;
        for (int c = 0; c < 3; c++) begin
          a = (acc[c] < 0) ? -acc[c] : acc[c];
          if (a > mx) mx = a;
        end
      end
    end
    n_vec++;
    if (mx > 10) begin
      n_err++;
      $display("FAIL dc_bound: got max |disparity| %0d expected <= 10", mx);
    end
  endtask

  task automatic test_mixed();
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           rc(), rc(), rc());
      n_vec++;
      if (obs_word() !== exp_w) begin
        n_err++;
        $display("FAIL mixed_model[%0d]: got %h expected %h", i, obs_word(), exp_w);
      end
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 1'b1, 1'b1, rc(), rc(), rc());
      n_vec++;
      if (obs_word() !== exp_w) begin
        n_err++;
        $display("FAIL premreset_model[%0d]: got %h expected %h", i, obs_word(), exp_w);
      end
    end
    reset_i = 1'b1;
    #1;
    n_vec++;
    if (obs_word() !== {3'b000, TOK00, TOK00, TOK00}) begin
      n_err++;
      $display("FAIL reset_async: got %h expected %h", obs_word(), {3'b000, TOK00, TOK00, TOK00});
    end
    @(posedge clk);
    #1;
    n_vec++;
    if (obs_word() !== {3'b000, TOK00, TOK00, TOK00}) begin
      n_err++;
      $display("FAIL reset_mid_held: got %h expected %h", obs_word(), {3'b000, TOK00, TOK00, TOK00});
    end
    reset_i = 1'b0;
    model_reset();
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rc(), rc(), rc());
      n_vec++;
      if (obs_word() !== exp_w) begin
        n_err++;
        $display("FAIL post_reset_model[%0d]: got %h expected %h", i, obs_word(), exp_w);
      end
    end
  endtask

  task automatic test_sync_invert();
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 1'b0, rc(), rc(), rc());
      n_vec++;
      if (obs_word() !== exp_w) begin
        n_err++;
        $display("FAIL invert_main_model[%0d]: got %h expected %h", i, obs_word(), exp_w);
      end
    end
    n_vec++;
    if (inv_blue !== 10'b1010101011 || inv_green !== TOK00 || inv_red !== TOK00 ||
        inv_hs !== 1'b1 || inv_vs !== 1'b1 || inv_de !== 1'b0) begin
      n_err++;
      $display("FAIL sync_invert: got b=%b g=%b r=%b hs=%b vs=%b de=%b expected b=1010101011 g=r=%b hs=1 vs=1 de=0",
               inv_blue, inv_green, inv_red, inv_hs, inv_vs, inv_de, TOK00);
    end
  endtask

  initial begin
    test_reset();
    test_blanking();
    test_black();
    test_white();
    test_dc_balance();
    test_mixed();
    test_reset_mid();
    test_sync_invert();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
